dmem_bus_ctrl: RTL
==================

// Module: dmem_bus_ctrl
// PURPOSE
//  Data-memory bus controller between the MEM stage and the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
//  Adds ACKD_n wait-state handling, pipeline stall generation, byte-lane steering, sign/zero extension and bus timeout.
//  Generalised over address/data width and timeout depth.
// PARAMETERS
//  ADDR_W   32  address bus width
//  DATA_W   32  data bus width; must be 32, since lane logic assumes 4 byte lanes
//  TIMEOUT  15  MREQ cycles without ACK before an error response; must be >=1
//  TO_W     $clog2(TIMEOUT+1)  wait-counter width, derived
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset
//  req_valid   in   1       MEM stage holds a load/store
//  req_write   in   1       1=store, 0=load
//  req_size    in   2       00 byte, 01 half, 10 word
//  req_signed  in   1       sign-extend load result
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   DATA_W  store data, LSB-aligned
//  stall       out  1       freeze IF..MEM pipeline registers
//  rsp_valid   out  1       one-cycle response strobe
//  rsp_rdata   out  DATA_W  extended load data; 0 for stores and errors
//  rsp_err     out  1       timeout or misalignment, qualified by rsp_valid
//  DAD         out  ADDR_W  bus address
//  DDT_o       out  DATA_W  bus write data
//  DDT_oe      out  1       DDT tri-state enable (top: DDT = DDT_oe ? DDT_o : 'z)
//  DDT_i       in   DATA_W  bus read data
//  MREQ        out  1       request, active high
//  WRITE       out  1       write strobe, active high
//  SIZE        out  2       same encoding as req_size
//  ACKD_n      in   1       acknowledge, active low
// BEHAVIOUR
//  Single clock clk. Reset rst is synchronous and active-high.
//  Reset values: state=IDLE; MREQ, WRITE, DDT_oe, rsp_valid, rsp_err, stall = 0; DAD, DDT_o, SIZE, rsp_rdata, wait_cnt = 0.
//  rst asserted mid-access: the next edge forces the reset values; the bus transaction is abandoned and no response is issued.
//  FSM states: IDLE, ACCESS, RESP. All bus outputs are registered.
//   IDLE: if req_valid and the request is legal, latch addr/size/signed/wdata and go to ACCESS (MREQ=1 from the next cycle).
//    If req_valid and the request is misaligned (trap enabled), go to RESP with err=1; no bus cycle.
//   ACCESS: MREQ held and bus outputs stable. ACKD_n sampled every edge.
//    ACKD_n=0: capture DDT_i, go to RESP.
//    Else wait_cnt++; when wait_cnt==TIMEOUT-1 and ACKD_n=1, go to RESP with err=1.
//    An ACK on the timeout cycle wins and the response is not an error.
//   RESP: rsp_valid=1 for exactly 1 cycle; MREQ=0, DDT_oe=0; unconditional return to IDLE.
//    A request is never accepted in RESP, because the pipeline advances at the end of RESP.
//  stall (combinational) = (state==IDLE & req_valid) | (state==ACCESS). It is low in RESP.
//  Latency: request in cycle T -> MREQ in T+1. ACK in T+1+k -> rsp_valid in T+2+k. Minimum 2 cycles.
//  Store lanes: byte data replicated x4, half data replicated x2, word as-is. DDT_oe=WRITE=req_write during ACCESS.
//  Load extraction, little-endian:
//   byte = DDT_i[8*a+7:8*a], a=addr[1:0]
//   half = DDT_i[16*addr[1]+15:16*addr[1]]
//   Result extended to DATA_W by req_signed.
//  Alignment rules: half requires addr[0]=0; word requires addr[1:0]=0.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined: a misaligned request produces rsp_valid+rsp_err one cycle later, with MREQ never asserted.
//  Not defined: misaligned addresses are force-aligned (half clears bit 0, word clears bits 1:0) and the access proceeds normally; rsp_err is only ever set by timeout.
// STRUCTURE
//  constants.v additions:
//   SIZE encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
//   FSM encodings ST_IDLE, ST_ACCESS, ST_RESP
//  Sub-module dmem_lane_align (combinational):
//   store replication + load extraction/extension
//   instantiated once, shared by the write and read paths
// TESTING
//  1. Word load 0x100, ACKD_n=0 on the 3rd MREQ cycle, DDT_i=0xDEADBEEF -> rsp_rdata=0xDEADBEEF, rsp_valid 1 cycle, stall high 4 cycles.
//  2. Byte load 0x103, DDT_i=0x80123456: signed -> 0xFFFFFF80; unsigned -> 0x00000080.
//  3. Half store 0x202, req_wdata=0x1234ABCD -> DDT_o=0xABCDABCD, SIZE=01, WRITE=1, DDT_oe=1, DAD=0x202.
//  4. Word load, ACKD_n held 1 -> after 15 MREQ cycles rsp_valid=1, rsp_err=1, rsp_rdata=0, MREQ=0.
//  5. Word load 0x101: trap defined -> rsp_err in T+1, MREQ never 1; undefined -> DAD=0x100, normal response.
//  6. rst=1 during ACCESS -> next cycle MREQ=0, stall=0, rsp_valid=0; a new request 2 cycles later completes normally.

Source files
------------

// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared encodings and alignment helpers for the data-memory bus controller.
// Used by dmem_bus_ctrl (optional build macro DMEM_MISALIGN_TRAP_EN) and dmem_lane_align.
package dmem_bus_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // The unused size code 2'b11 is handled as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      default: is_misaligned = |lo;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: align_lo = lo;
      SZ_HALF: align_lo = {lo[1], 1'b0};
      default: align_lo = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store-data replication and little-endian load extraction with sign/zero extension.
// Purely combinational; one instance serves both the write and the read path.
module dmem_lane_align
  import dmem_bus_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
)(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = bus_rdata[{addr_lo, 3'b000} +: 8];
    half_sel  = bus_rdata[{addr_lo[1], 4'b0000} +: 16];
    bus_wdata = wdata;
    rdata     = bus_rdata;
    case (size)
      SZ_BYTE: begin
        bus_wdata = {(DATA_W/8){wdata[7:0]}};
        rdata     = {{(DATA_W-8){is_signed & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        bus_wdata = {(DATA_W/16){wdata[15:0]}};
        rdata     = {{(DATA_W-16){is_signed & half_sel[15]}}, half_sel};
      end
      default: begin
        bus_wdata = wdata;
        rdata     = bus_rdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: registered bus cycle with ACKD_n wait states, stall, timeout and responses.
// Build macro DMEM_MISALIGN_TRAP_EN: misaligned requests trap instead of being force-aligned.
module dmem_bus_ctrl
  import dmem_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] DAD,
  output logic [DATA_W-1:0] DDT_o,
  output logic              DDT_oe,
  input  logic [DATA_W-1:0] DDT_i,
  output logic              MREQ,
  output logic              WRITE,
  output logic [1:0]        SIZE,
  input  logic              ACKD_n
);

  state_e            state, state_next;
  logic [TO_W-1:0]   wait_cnt;
  logic              signed_q;
  logic              trap_req;
  logic [ADDR_W-1:0] aligned_addr;
  logic              ack, timeout;
  logic [1:0]        lane_size, lane_lo;
  logic [DATA_W-1:0] lane_wdata, lane_rdata;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap_req     = is_misaligned(req_size, req_addr[1:0]);
  assign aligned_addr = req_addr;
`else
  assign trap_req     = 1'b0;
  assign aligned_addr = {req_addr[ADDR_W-1:2], align_lo(req_size, req_addr[1:0])};
`endif

  assign ack     = ~ACKD_n;
  assign timeout = (wait_cnt == TO_W'(TIMEOUT - 1));

  // In IDLE the lanes steer the incoming store data; afterwards they decode the latched access.
  assign lane_size = (state == ST_IDLE) ? req_size : SIZE;
  assign lane_lo   = (state == ST_IDLE) ? aligned_addr[1:0] : DAD[1:0];

  dmem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .size      (lane_size),
    .addr_lo   (lane_lo),
    .is_signed (signed_q),
    .wdata     (req_wdata),
    .bus_rdata (DDT_i),
    .bus_wdata (lane_wdata),
    .rdata     (lane_rdata)
  );

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = req_valid;
        if (req_valid) state_next = trap_req ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        stall = 1'b1;
        if (ack || timeout) state_next = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      signed_q  <= 1'b0;
      MREQ      <= 1'b0;
      WRITE     <= 1'b0;
      DDT_oe    <= 1'b0;
      DAD       <= '0;
      DDT_o     <= '0;
      SIZE      <= SZ_BYTE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (trap_req) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              MREQ     <= 1'b1;
              WRITE    <= req_write;
              DDT_oe   <= req_write;
              DAD      <= aligned_addr;
              SIZE     <= req_size;
              DDT_o    <= lane_wdata;
              signed_q <= req_signed;
              wait_cnt <= '0;
            end
          end
        end
        ST_ACCESS: begin
          // An acknowledge on the final timeout cycle still counts as a good response.
          if (ack || timeout) begin
            MREQ      <= 1'b0;
            WRITE     <= 1'b0;
            DDT_oe    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= ~ack;
            rsp_rdata <= (ack && !WRITE) ? lane_rdata : '0;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
      endcase
    end
  end

endmodule
